// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory bus for mem_access_ctrl.
// slave = controller side, master = requester side.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rd,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_address, mem_wd,
    output mem_we, mem_re
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rd,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_address, mem_wd,
    input  mem_we, mem_re
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: byte-addressed requests to a word memory.
// Optional `MISALIGN_CHECK_EN reports misaligned accesses as errors.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  state_t          state_q;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            we_q;
  logic            uns_q;
  logic [DW-1:0]   wdata_q;

  logic            req_ready_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [DW-1:0]   resp_rdata_q;
  logic [AW-1:0]   mem_address_q;
  logic [DW-1:0]   mem_wd_q;
  logic            mem_we_q;
  logic            mem_re_q;

  logic            mis_d;
  logic [1:0]      off_d;
  logic [AW-1:0]   widx_d;
  logic [DW-1:0]   sh_d;
  logic [DW-1:0]   load_d;
  logic [DW-1:0]   wmask_d;
  logic [DW-1:0]   merge_d;

  assign widx_d = {2'b00, bus.req_addr[AW-1:2]};

  // Misalignment detection and lane offset of the incoming request.
  always_comb begin
    mis_d = 1'b0;
    off_d = bus.req_addr[1:0];
`ifdef MISALIGN_CHECK_EN
    mis_d = (bus.req_size == 2'b01 && bus.req_addr[0])
         || (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
    unique case (bus.req_size)
      2'b00:   off_d = bus.req_addr[1:0];
      2'b01:   off_d = {bus.req_addr[1], 1'b0};
      default: off_d = 2'b00;
    endcase
`endif
  end

  // Load extension and store merge on the word read from memory.
  always_comb begin
    sh_d = bus.mem_rd >> {off_q, 3'b000};
    unique case (size_q)
      2'b00: begin
        load_d  = uns_q
          ? {{(DW-8){1'b0}}, sh_d[7:0]}
          : {{(DW-8){sh_d[7]}}, sh_d[7:0]};
        wmask_d = {{(DW-8){1'b0}}, 8'hFF}
                  << {off_q, 3'b000};
      end
      2'b01: begin
        load_d  = uns_q
          ? {{(DW-16){1'b0}}, sh_d[15:0]}
          : {{(DW-16){sh_d[15]}}, sh_d[15:0]};
        wmask_d = {{(DW-16){1'b0}}, 16'hFFFF}
                  << {off_q, 3'b000};
      end
      default: begin
        load_d  = bus.mem_rd;
        wmask_d = '1;
      end
    endcase
    merge_d = (bus.mem_rd & ~wmask_d)
            | ((wdata_q << {off_q, 3'b000}) & wmask_d);
  end

  // Access FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      off_q         <= '0;
      size_q        <= '0;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      wdata_q       <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_wd_q      <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            off_q       <= off_d;
            size_q      <= bus.req_size;
            we_q        <= bus.req_we;
            uns_q       <= bus.req_unsigned;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (mis_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!bus.req_we
                         || !bus.req_size[1]) begin
              state_q       <= READ;
              mem_re_q      <= 1'b1;
              mem_address_q <= widx_d;
            end else begin
              state_q       <= WRITE;
              mem_we_q      <= 1'b1;
              mem_wd_q      <= bus.req_wdata;
              mem_address_q <= widx_d;
            end
          end
        end
        READ: begin
          mem_re_q <= 1'b0;
          if (we_q) begin
            state_q  <= WRITE;
            mem_we_q <= 1'b1;
            mem_wd_q <= merge_d;
          end else begin
            state_q       <= RESP;
            mem_address_q <= '0;
            resp_valid_q  <= 1'b1;
            resp_rdata_q  <= load_d;
          end
        end
        WRITE: begin
          state_q       <= RESP;
          mem_we_q      <= 1'b0;
          mem_wd_q      <= '0;
          mem_address_q <= '0;
          resp_valid_q  <= 1'b1;
          resp_rdata_q  <= '0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wd      = mem_wd_q;
  assign bus.mem_we      = mem_we_q & rst_n;
  assign bus.mem_re      = mem_re_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 16-word memory model.
// Honors `MISALIGN_CHECK_EN when the design is built with it.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] mem [0:15];

  int total  = 0;
  int passed = 0;

  int          r_lat;
  logic        r_saw_re;
  logic        r_saw_we;
  logic [31:0] r_addr;
  logic [31:0] held;

  mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_address[3:0]];

  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_address[3:0]] <= bus.mem_wd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // Issue one request and wait (bounded) for resp_valid.
  task automatic xact(input logic we,
                      input logic [1:0] sz,
                      input logic uns,
                      input logic [31:0] addr,
                      input logic [31:0] wd);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    r_lat    = 1;
    r_saw_re = 1'b0;
    r_saw_we = 1'b0;
    r_addr   = '0;
    while (!bus.resp_valid && r_lat < 10) begin
      if (bus.mem_re) begin
        r_saw_re = 1'b1;
        r_addr   = bus.mem_address;
      end
      if (bus.mem_we) r_saw_we = 1'b1;
      if (bus.mem_re && bus.mem_we)
        chk("re_we_excl", 32'd1, 32'd0);
      @(posedge clk); #1;
      r_lat++;
    end
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    mem[0] = 32'h0000_0003;
    mem[1] = 32'h1122_3380;
    mem[2] = 32'hAABB_CCDD;
    mem[3] = 32'h0000_0000;
    mem[4] = 32'h0000_0000;
    for (int i = 5; i < 15; i++) mem[i] = 32'h0101_0101 * i;
    mem[15] = 32'hCAFE_F00D;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_re",     32'(bus.mem_re),     32'd0);
    chk("rst_mem_addr",   bus.mem_address,     32'h0);
    chk("rst_rdata",      bus.resp_rdata,      32'h0);

    // Word load
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("t1_lat",   32'(r_lat), 32'd2);
    chk("t1_rdata", bus.resp_rdata, 32'h0000_0003);
    chk("t1_err",   32'(bus.resp_err), 32'd0);
    consume();
    chk("t1_ready_after", 32'(bus.req_ready), 32'd1);
    chk("t1_valid_after", 32'(bus.resp_valid), 32'd0);

    // Byte loads, signed and unsigned
    xact(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    chk("t2_sbyte", bus.resp_rdata, 32'hFFFF_FF80);
    consume();
    xact(1'b0, 2'b00, 1'b1, 32'h4, 32'h0);
    chk("t2_ubyte", bus.resp_rdata, 32'h0000_0080);
    consume();
    xact(1'b0, 2'b00, 1'b0, 32'h6, 32'h0);
    chk("t2_byte2", bus.resp_rdata, 32'h0000_0022);
    consume();

    // Sub-word stores with read-modify-write
    xact(1'b1, 2'b00, 1'b0, 32'hA, 32'hFFFF_FF5A);
    chk("t3_lat",   32'(r_lat), 32'd3);
    chk("t3_re",    32'(r_saw_re), 32'd1);
    chk("t3_we",    32'(r_saw_we), 32'd1);
    chk("t3_rdata", bus.resp_rdata, 32'h0);
    chk("t3_mem",   mem[2], 32'hAA5A_CCDD);
    consume();

    xact(1'b1, 2'b01, 1'b0, 32'hE, 32'h1234_BEEF);
    chk("t4_lat", 32'(r_lat), 32'd3);
    chk("t4_mem", mem[3], 32'hBEEF_0000);
    consume();
    xact(1'b0, 2'b01, 1'b1, 32'hE, 32'h0);
    chk("t4_uhalf", bus.resp_rdata, 32'h0000_BEEF);
    consume();
    xact(1'b0, 2'b01, 1'b0, 32'hE, 32'h0);
    chk("t4_shalf", bus.resp_rdata, 32'hFFFF_BEEF);
    consume();

    // Word store straight to WRITE
    xact(1'b1, 2'b10, 1'b0, 32'h14, 32'h1234_5678);
    chk("ws_lat", 32'(r_lat), 32'd2);
    chk("ws_re",  32'(r_saw_re), 32'd0);
    chk("ws_mem", mem[5], 32'h1234_5678);
    consume();

    // Top-of-range address wraps into the word index
    xact(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_addr",  r_addr, 32'h3FFF_FFFF);
    chk("wrap_rdata", bus.resp_rdata, 32'hCAFE_F00D);
    consume();

    // Misaligned word load
    xact(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("t5_lat",   32'(r_lat), 32'd1);
    chk("t5_err",   32'(bus.resp_err), 32'd1);
    chk("t5_rdata", bus.resp_rdata, 32'h0);
    chk("t5_re",    32'(r_saw_re), 32'd0);
`else
    chk("t5_lat",   32'(r_lat), 32'd2);
    chk("t5_err",   32'(bus.resp_err), 32'd0);
    chk("t5_rdata", bus.resp_rdata, 32'h1122_3380);
`endif
    consume();

    // Reset taken while in WRITE
    chk("t6_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("t6_in_write", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_we_gated", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_mem",   mem[4], 32'h0);
    chk("t6_ready_after", 32'(bus.req_ready), 32'd1);
    chk("t6_valid_after", 32'(bus.resp_valid), 32'd0);

    // Response held under backpressure
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    held = bus.resp_rdata;
    chk("hold_first", held, 32'h0000_0003);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, 32'h0000_0003);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    consume();
    chk("hold_release", 32'(bus.resp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
